mips_multicycle_ctrl: RTL

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/mips_ctrl_decode.sv | 81 ++++++++
 rtl/mips_multicycle_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg -- shared definitions for the multicycle MIPS controller.
//   state_t   : controller state encodings (also driven out on the debug port)
//   OP_*      : instruction[31:26] opcodes the controller understands
//   ALU_*     : alu_op codes handed to the ALU control block
//   PC_*/SRCB_*: pc_source and alu_src_b mux selects
//   ctrl_t    : bundle of every datapath control produced by the decoder
// Optional macro MIPS_CTRL_ADDI_EN adds the ADDIEX/ADDIWB states for addi.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
`ifdef MIPS_CTRL_ADDI_EN
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
`endif
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
  } ctrl_t;

  // States that wait on mem_ready and therefore feed the wait counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode -- combinational state-to-control decode.
// Ports:
//   state     in  current controller state
//   mem_ready in  memory completes this cycle (gates FETCH ir_write/pc_write)
//   reset     in  active-low reset level; forces memory/PC/IR strobes off
//   ctrl      out all datapath controls
// Macro MIPS_CTRL_ADDI_EN adds the ADDIEX/ADDIWB rows.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       reset,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // IR and PC update only on the cycle the fetch actually completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
`endif
      default: ;  // HALT and unused codes: everything off
    endcase

    // During reset the state register already reads FETCH; keep its
    // strobes from touching memory, IR or PC until reset is released.
    if (!reset) begin
      ctrl.mem_read = 1'b0;
      ctrl.ir_write = 1'b0;
      ctrl.pc_write = 1'b0;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl -- multicycle MIPS control unit (state register,
// memory-wait watchdog, next-state logic; outputs via mips_ctrl_decode).
// Ports:
//   clk, reset (async, active-low)
//   opcode     instruction[31:26]
//   mem_ready  memory access completes this cycle
//   pc_write .. reg_dst, pc_source, alu_op, alu_src_b : datapath controls
//   state      current state (debug), halted, err (halt was a fault)
// Parameter MEM_TIMEOUT: consecutive not-ready cycles before a fault, 0 = off.
// Macro MIPS_CTRL_ADDI_EN enables addi (ADDIEX/ADDIWB); otherwise addi faults.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic [3:0] state,
  output logic       halted,
  output logic       err
);

  localparam logic       TIMEOUT_EN   = (MEM_TIMEOUT != 0);
  // Counter value seen on the MEM_TIMEOUT-th consecutive not-ready cycle.
  localparam logic [7:0] TIMEOUT_LAST = (MEM_TIMEOUT == 0) ? 8'd0 : 8'(MEM_TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       err_reg, err_next;
  ctrl_t      ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= 8'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;

    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_next = S_ADDIEX;
`else
          OP_ADDI: begin
            state_next = S_HALT;
            err_next   = 1'b1;
          end
`endif
          OP_HALT:      state_next = S_HALT;
          default: begin
            state_next = S_HALT;
            err_next   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        // IR is stable here, so opcode still holds lw or sw.
        if (opcode == OP_LW) begin
          state_next = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_next = S_MEMWR;
        end else begin
          state_next = S_HALT;
          err_next   = 1'b1;
        end
      end
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXEC:   state_next = S_ALUWB;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
`endif
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default: begin
        state_next = S_HALT;
        err_next   = 1'b1;
      end
    endcase

    // Memory watchdog overrides the normal hold in a wait state.
    if (TIMEOUT_EN && is_mem_state(state_reg) && !mem_ready &&
        (wait_cnt_reg == TIMEOUT_LAST)) begin
      state_next = S_HALT;
      err_next   = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_next != state_reg) begin
      wait_cnt_next = 8'd0;
    end else if (is_mem_state(state_reg) && !mem_ready && (wait_cnt_reg != 8'hFF)) begin
      wait_cnt_next = wait_cnt_reg + 8'd1;
    end
  end

  mips_ctrl_decode u_decode (
    .state     (state_reg),
    .mem_ready (mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign ir_write      = ctrl.ir_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign alu_src_b     = ctrl.alu_src_b;
  assign state         = state_reg;
  assign halted        = (state_reg == S_HALT);
  assign err           = err_reg;

endmodule
